// File: rtl/ram_bank_write_ctrl_pkg.sv
// Shared constants and width helper for the RAM bank write controller.
package ram_bank_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/ram_bank_write_ctrl_ptr.sv
// Per-bank write pointer with full flag; the pointer wraps to zero on the
// write that fills the bank and then stays put until the bank is cleared.
module ram_bank_ptr import ram_bank_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] ptr,
  output logic              full,
  output logic              will_fill
);

  logic [ADDR_W-1:0] ptr_r;
  logic              full_r;
  logic              at_last_s;

  assign at_last_s = (ptr_r == ADDR_W'(DEPTH - 1));
  assign will_fill = inc & at_last_s;
  assign ptr       = ptr_r;
  assign full      = full_r;

  // Pointer and full flag: a clear has priority over an increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r  <= {ADDR_W{1'b0}};
      full_r <= 1'b0;
    end else if (clr) begin
      ptr_r  <= {ADDR_W{1'b0}};
      full_r <= 1'b0;
    end else if (inc) begin
      ptr_r  <= at_last_s ? {ADDR_W{1'b0}} : ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      full_r <= full_r | at_last_s;
    end else begin
      ptr_r  <= ptr_r;
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/ram_bank_write_ctrl.sv
// Steers processor write strobes into NUM_BANKS RAM banks, with per-bank
// pointers, full flags, sticky overflow and optional auto-advance on full.
module ram_bank_write_ctrl import ram_bank_pkg::*; #(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = clog2_min1(DEPTH),
  parameter int SEL_W     = clog2_min1(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_strobe,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 sel_strobe,
  input  logic [SEL_W-1:0]     sel_in,
  input  logic                 mode,
  input  logic [NUM_BANKS-1:0] full_clr,
  output logic [NUM_BANKS-1:0] ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_data,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic [SEL_W-1:0]     active_bank,
  output logic                 overflow
);

  logic [SEL_W-1:0]     active_bank_r;
  logic                 overflow_r;
  logic [NUM_BANKS-1:0] ram_we_r;
  logic [ADDR_W-1:0]    ram_addr_r;
  logic [DATA_W-1:0]    ram_data_r;

  logic [ADDR_W-1:0]    ptr_s [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_full_s;
  logic [NUM_BANKS-1:0] will_fill_s;
  logic [NUM_BANKS-1:0] sel_onehot_s;
  logic [NUM_BANKS-1:0] inc_s;
  logic [ADDR_W-1:0]    target_ptr_s;
  logic                 target_full_s;
  logic                 target_clr_s;
  logic                 accept_s;
  logic                 drop_s;
  logic                 fill_s;
  logic                 sel_valid_s;
  logic [SEL_W-1:0]     active_next_s;

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_bank
      ram_bank_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_s[g]),
        .clr       (full_clr[g]),
        .ptr       (ptr_s[g]),
        .full      (bank_full_s[g]),
        .will_fill (will_fill_s[g])
      );
    end
  endgenerate

  // Decode the active bank and mux its pointer without priority logic.
  always_comb begin
    sel_onehot_s = {NUM_BANKS{1'b0}};
    target_ptr_s = {ADDR_W{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_onehot_s[b] = (active_bank_r == SEL_W'(b));
      target_ptr_s    = target_ptr_s | (ptr_s[b] & {ADDR_W{sel_onehot_s[b]}});
    end
  end

  // A clear on the target bank swallows the write silently; a full bank drops it loudly.
  assign target_full_s = |(bank_full_s & sel_onehot_s);
  assign target_clr_s  = |(full_clr & sel_onehot_s);
  assign accept_s      = write_strobe & ~target_full_s & ~target_clr_s;
  assign drop_s        = write_strobe &  target_full_s & ~target_clr_s;
  assign inc_s         = sel_onehot_s & {NUM_BANKS{accept_s}};
  assign fill_s        = |will_fill_s;
  assign sel_valid_s   = ({1'b0, sel_in} < (SEL_W+1)'(NUM_BANKS));

  // Next active bank: explicit select beats auto-advance on fill.
  always_comb begin
    active_next_s = active_bank_r;
    if (sel_strobe && sel_valid_s) begin
      active_next_s = sel_in;
    end else if ((mode == MODE_AUTO) && fill_s) begin
      active_next_s = (active_bank_r == SEL_W'(NUM_BANKS - 1)) ? {SEL_W{1'b0}}
                                                              : active_bank_r + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      active_next_s = active_bank_r;
    end
  end

  // Output registers, active bank and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_bank_r <= {SEL_W{1'b0}};
      overflow_r    <= 1'b0;
      ram_we_r      <= {NUM_BANKS{1'b0}};
      ram_addr_r    <= {ADDR_W{1'b0}};
      ram_data_r    <= {DATA_W{1'b0}};
    end else begin
      active_bank_r <= active_next_s;
      overflow_r    <= overflow_r | drop_s;
      ram_we_r      <= inc_s;
      if (accept_s) begin
        ram_addr_r <= target_ptr_s;
        ram_data_r <= data_in;
      end else begin
        ram_addr_r <= ram_addr_r;
        ram_data_r <= ram_data_r;
      end
    end
  end

  assign ram_we      = ram_we_r;
  assign ram_addr    = ram_addr_r;
  assign ram_data    = ram_data_r;
  assign bank_full   = bank_full_s;
  assign active_bank = active_bank_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_ram_bank_write_ctrl.sv
// Directed bench for ram_bank_write_ctrl: a 2-bank and a 3-bank instance, DEPTH=4.
module tb_ram_bank_write_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 2-bank instance
  logic       reset, write_strobe, sel_strobe, mode;
  logic [7:0] data_in;
  logic [0:0] sel_in;
  logic [1:0] full_clr, ram_we, bank_full;
  logic [1:0] ram_addr;
  logic [7:0] ram_data;
  logic [0:0] active_bank;
  logic       overflow;

  // 3-bank instance
  logic       reset3, write_strobe3, sel_strobe3, mode3;
  logic [7:0] data_in3;
  logic [1:0] sel_in3;
  logic [2:0] full_clr3, ram_we3, bank_full3;
  logic [1:0] ram_addr3;
  logic [7:0] ram_data3;
  logic [1:0] active_bank3;
  logic       overflow3;

  int n_checks = 0;
  int n_fail   = 0;

  ram_bank_write_ctrl #(.NUM_BANKS(2), .DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .data_in(data_in),
    .sel_strobe(sel_strobe), .sel_in(sel_in), .mode(mode), .full_clr(full_clr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .bank_full(bank_full), .active_bank(active_bank), .overflow(overflow)
  );

  ram_bank_write_ctrl #(.NUM_BANKS(3), .DEPTH(4), .DATA_W(8)) dut3 (
    .clk(clk), .reset(reset3), .write_strobe(write_strobe3), .data_in(data_in3),
    .sel_strobe(sel_strobe3), .sel_in(sel_in3), .mode(mode3), .full_clr(full_clr3),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_data(ram_data3),
    .bank_full(bank_full3), .active_bank(active_bank3), .overflow(overflow3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    write_strobe = 1'b1;
    data_in      = d;
    cycle();
    write_strobe = 1'b0;
  endtask

  task automatic wr3(input logic [7:0] d);
    write_strobe3 = 1'b1;
    data_in3      = d;
    cycle();
    write_strobe3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write_strobe = 1'b0; sel_strobe = 1'b0; mode = 1'b0;
    data_in = 8'h00; sel_in = 1'b0; full_clr = 2'b00;
    reset3 = 1'b1; write_strobe3 = 1'b0; sel_strobe3 = 1'b0; mode3 = 1'b0;
    data_in3 = 8'h00; sel_in3 = 2'd0; full_clr3 = 3'b000;
    #2;
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state
    chk("rst_we",   32'(ram_we),      32'h0);
    chk("rst_addr", 32'(ram_addr),    32'h0);
    chk("rst_data", 32'(ram_data),    32'h0);
    chk("rst_full", 32'(bank_full),   32'h0);
    chk("rst_act",  32'(active_bank), 32'h0);
    chk("rst_ovf",  32'(overflow),    32'h0);

    // 1: direct fill of bank 0, then overflow
    for (int i = 0; i < 4; i++) begin
      wr(8'hA0 + 8'(i));
      chk("t1_we",   32'(ram_we),    32'h1);
      chk("t1_addr", 32'(ram_addr),  32'(i));
      chk("t1_data", 32'(ram_data),  32'hA0 + 32'(i));
      chk("t1_full", 32'(bank_full), (i == 3) ? 32'h1 : 32'h0);
    end
    cycle();
    chk("t1_we_idle", 32'(ram_we), 32'h0);
    wr(8'hA4);
    chk("t1_drop_we",   32'(ram_we),   32'h0);
    chk("t1_ovf",       32'(overflow), 32'h1);
    chk("t1_hold_addr", 32'(ram_addr), 32'h3);
    chk("t1_hold_data", 32'(ram_data), 32'hA3);

    // 2: auto-advance across both banks
    do_reset();
    chk("t2_ovf_clr", 32'(overflow), 32'h0);
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr(8'h10 + 8'(i));
      chk("t2_we",   32'(ram_we),   (i < 4) ? 32'h1 : 32'h2);
      chk("t2_addr", 32'(ram_addr), 32'(i % 4));
      chk("t2_data", 32'(ram_data), 32'h10 + 32'(i));
      if (i == 3) chk("t2_act1", 32'(active_bank), 32'h1);
    end
    chk("t2_full", 32'(bank_full),   32'h3);
    chk("t2_act0", 32'(active_bank), 32'h0);
    chk("t2_ovf0", 32'(overflow),    32'h0);
    wr(8'h99);
    chk("t2_drop_we", 32'(ram_we),   32'h0);
    chk("t2_ovf",     32'(overflow), 32'h1);
    mode = 1'b0;

    // 3: select in the same cycle as a write
    do_reset();
    write_strobe = 1'b1; data_in = 8'h55; sel_strobe = 1'b1; sel_in = 1'b1;
    cycle();
    write_strobe = 1'b0; sel_strobe = 1'b0;
    chk("t3_we",   32'(ram_we),      32'h1);
    chk("t3_data", 32'(ram_data),    32'h55);
    chk("t3_act",  32'(active_bank), 32'h1);
    wr(8'h66);
    chk("t3_we2",   32'(ram_we),   32'h2);
    chk("t3_addr2", 32'(ram_addr), 32'h0);
    chk("t3_data2", 32'(ram_data), 32'h66);

    // 4: clear of an unrelated bank does not block a write; clear of target does
    do_reset();
    wr(8'h30);
    write_strobe = 1'b1; data_in = 8'h31; full_clr = 2'b10;
    cycle();
    write_strobe = 1'b0; full_clr = 2'b00;
    chk("t4_other_we",   32'(ram_we),   32'h1);
    chk("t4_other_addr", 32'(ram_addr), 32'h1);
    wr(8'h32);
    wr(8'h33);
    chk("t4_full", 32'(bank_full), 32'h1);
    write_strobe = 1'b1; data_in = 8'h77; full_clr = 2'b01;
    cycle();
    write_strobe = 1'b0; full_clr = 2'b00;
    chk("t4_clr_we",   32'(ram_we),    32'h0);
    chk("t4_clr_ovf",  32'(overflow),  32'h0);
    chk("t4_clr_full", 32'(bank_full), 32'h0);
    wr(8'h88);
    chk("t4_we",   32'(ram_we),   32'h1);
    chk("t4_addr", 32'(ram_addr), 32'h0);
    chk("t4_data", 32'(ram_data), 32'h88);

    // 5: three banks, out-of-range select and mid-burst reset
    reset3 = 1'b0;
    sel_strobe3 = 1'b1; sel_in3 = 2'd2;
    cycle();
    chk("t5_sel2", 32'(active_bank3), 32'h2);
    sel_in3 = 2'd3;
    cycle();
    sel_strobe3 = 1'b0;
    chk("t5_sel3_ign", 32'(active_bank3), 32'h2);
    wr3(8'hC0);
    chk("t5_we",   32'(ram_we3),   32'h4);
    chk("t5_addr", 32'(ram_addr3), 32'h0);
    wr3(8'hC1);
    chk("t5_addr1", 32'(ram_addr3), 32'h1);
    reset3 = 1'b1; write_strobe3 = 1'b1; data_in3 = 8'hC2;
    cycle();
    reset3 = 1'b0; write_strobe3 = 1'b0;
    chk("t5_rst_we",   32'(ram_we3),      32'h0);
    chk("t5_rst_addr", 32'(ram_addr3),    32'h0);
    chk("t5_rst_data", 32'(ram_data3),    32'h0);
    chk("t5_rst_full", 32'(bank_full3),   32'h0);
    chk("t5_rst_act",  32'(active_bank3), 32'h0);
    chk("t5_rst_ovf",  32'(overflow3),    32'h0);
    wr3(8'hD0);
    chk("t5_post_we",   32'(ram_we3),   32'h1);
    chk("t5_post_addr", 32'(ram_addr3), 32'h0);
    chk("t5_post_data", 32'(ram_data3), 32'hD0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
